// File: rtl/axi_aw_w_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_mux_ctrl_pkg
// Brief   : Shared types and helpers for the AXI AW/W write-path multiplexer.
// Revision: 1.0 - initial release
// ============================================================================
package axi_mux_ctrl_pkg;

    // Upper bound on the number of inputs rr_pick can arbitrate between.
    localparam int unsigned MAX_IN         = 32;
    localparam int unsigned NUM_IN_DEFAULT = 4;
    localparam int unsigned IDX_W          = (NUM_IN_DEFAULT > 1) ? $clog2(NUM_IN_DEFAULT) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } aw_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of valid at or after ptr, wrapping modulo n; 0 if none.
    function automatic int unsigned rr_pick(input logic [MAX_IN-1:0] valid,
                                            input int unsigned       ptr,
                                            input int unsigned       n);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_IN; k++) begin
            if (!found && (k < n)) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[$clog2(MAX_IN)-1:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage : axi_mux_ctrl_pkg
`default_nettype wire

// File: rtl/axi_aw_w_mux_ctrl_idx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : axi_mux_idx_fifo
// Brief   : Small index FIFO recording AW grant order for W routing.
// Revision: 1.0 - initial release
// ============================================================================
module axi_mux_idx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_test_en;

    // No internal scan structures, so test mode has nothing to steer here.
    assign w_unused_test_en = test_en_i;

    assign full_o  = (r_count == c_cnt_w'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule : axi_mux_idx_fifo
`default_nettype wire

// File: rtl/axi_aw_w_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : axi_aw_w_mux_ctrl
// Brief   : Round-robin AW arbiter with grant-ordered W routing onto one port.
// Revision: 1.0 - initial release
// ============================================================================
module axi_aw_w_mux_ctrl
    import axi_mux_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned AW_WIDTH   = 64,
    parameter int unsigned W_WIDTH    = 72,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        test_en_i,
    input  logic [NUM_IN-1:0]           slave_aw_valid_i,
    input  logic [NUM_IN*AW_WIDTH-1:0]  slave_aw_data_i,
    output logic [NUM_IN-1:0]           slave_aw_ready_o,
    input  logic [NUM_IN-1:0]           slave_w_valid_i,
    input  logic [NUM_IN*W_WIDTH-1:0]   slave_w_data_i,
    input  logic [NUM_IN-1:0]           slave_w_last_i,
    output logic [NUM_IN-1:0]           slave_w_ready_o,
    output logic                        master_aw_valid_o,
    output logic [AW_WIDTH-1:0]         master_aw_data_o,
    output logic [$clog2(NUM_IN)-1:0]   master_aw_idx_o,
    input  logic                        master_aw_ready_i,
    output logic                        master_w_valid_o,
    output logic [W_WIDTH-1:0]          master_w_data_o,
    output logic                        master_w_last_o,
    input  logic                        master_w_ready_i
);

    localparam int unsigned c_idx_w = idx_width(NUM_IN);

    aw_state_e          r_state;
    aw_state_e          w_state_nxt;
    logic [c_idx_w-1:0] r_rr_ptr;
    logic [c_idx_w-1:0] w_rr_ptr_nxt;
    logic [c_idx_w-1:0] r_lock_idx;
    logic [c_idx_w-1:0] w_lock_idx_nxt;
    logic [c_idx_w-1:0] w_pick;
    logic [c_idx_w-1:0] w_grant;
    logic               w_aw_valid;
    logic               w_aw_hs;
    logic [MAX_IN-1:0]  w_valid_ext;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_idx_w-1:0] w_fifo_head;
    logic [c_idx_w-1:0] w_w_sel;
    logic               w_w_pop;

    logic [AW_WIDTH-1:0] w_aw_data_arr [NUM_IN];
    logic [W_WIDTH-1:0]  w_w_data_arr  [NUM_IN];

    always_comb begin
        w_valid_ext               = '0;
        w_valid_ext[NUM_IN-1:0]   = slave_aw_valid_i;
    end

    assign w_pick = c_idx_w'(rr_pick(w_valid_ext, 32'(r_rr_ptr), NUM_IN));

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant        = '0;
        w_aw_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant = w_pick;
                // rst_ni gate keeps every output valid low while reset is held.
                if (rst_ni && (|slave_aw_valid_i) && !w_fifo_full) begin
                    w_aw_valid = 1'b1;
                    if (!master_aw_ready_i) begin
                        w_state_nxt    = LOCKED;
                        w_lock_idx_nxt = w_pick;
                    end
                end
            end
            LOCKED: begin
                w_grant    = r_lock_idx;
                w_aw_valid = slave_aw_valid_i[r_lock_idx];
                if (w_aw_valid && master_aw_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_aw_hs = w_aw_valid && master_aw_ready_i;
        if (w_aw_hs) begin
            w_rr_ptr_nxt = (w_grant == c_idx_w'(NUM_IN - 1)) ? '0 : w_grant + c_idx_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

    axi_mux_idx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_idx_w)
    ) u_idx_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .test_en_i (test_en_i),
        .push_i    (w_aw_hs),
        .pop_i     (w_w_pop),
        .data_i    (w_grant),
        .data_o    (w_fifo_head),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    // Empty FIFO parks the W mux on input 0 so data outputs stay defined.
    assign w_w_sel = w_fifo_empty ? '0 : w_fifo_head;

    assign master_aw_valid_o = w_aw_valid;
    assign master_aw_idx_o   = w_grant;
    assign master_aw_data_o  = w_aw_data_arr[w_grant];

    assign master_w_valid_o  = !w_fifo_empty && slave_w_valid_i[w_w_sel];
    assign master_w_data_o   = w_w_data_arr[w_w_sel];
    assign master_w_last_o   = slave_w_last_i[w_w_sel];
    assign w_w_pop           = master_w_valid_o && master_w_ready_i && master_w_last_o;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_port
        assign w_aw_data_arr[g]    = slave_aw_data_i[g*AW_WIDTH +: AW_WIDTH];
        assign w_w_data_arr[g]     = slave_w_data_i[g*W_WIDTH +: W_WIDTH];
        assign slave_aw_ready_o[g] = w_aw_valid && (w_grant == c_idx_w'(g)) && master_aw_ready_i;
        assign slave_w_ready_o[g]  = !w_fifo_empty && (w_fifo_head == c_idx_w'(g)) && master_w_ready_i;
    end

endmodule : axi_aw_w_mux_ctrl
`default_nettype wire

// File: tb/tb_axi_aw_w_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_aw_w_mux_ctrl
// Brief   : Randomized scoreboard bench for the AXI AW/W write-path mux.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_aw_w_mux_ctrl;

    localparam int N     = 4;
    localparam int AWW   = 64;
    localparam int WW    = 72;
    localparam int DEPTH = 4;
    localparam int RING  = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               test_en = 1'b0;
    logic [N-1:0]       aw_valid = '0;
    logic [N*AWW-1:0]   aw_data = '0;
    logic [N-1:0]       aw_ready;
    logic [N-1:0]       w_valid = '0;
    logic [N*WW-1:0]    w_data = '0;
    logic [N-1:0]       w_last = '0;
    logic [N-1:0]       w_ready;
    logic               m_aw_valid;
    logic [AWW-1:0]     m_aw_data;
    logic [$clog2(N)-1:0] m_aw_idx;
    logic               m_aw_ready = 1'b0;
    logic               m_w_valid;
    logic [WW-1:0]      m_w_data;
    logic               m_w_last;
    logic               m_w_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-input burst-length rings: one entry per AW issued, consumed by W.
    int wlen_buf [N][RING];
    int wl_head  [N];
    int wl_cnt   [N];
    int wbeat    [N];
    logic [N-1:0] aw_hs_seen = '0;
    logic [N-1:0] w_hs_seen  = '0;

    // Reference model: grant order queue and pending round-robin choice.
    int m_fifo [$];
    int m_ptr = 0;
    int m_cur = -1;

    int             exp_aw_idx  [$];
    logic [AWW-1:0] exp_aw_dat  [$];
    logic [WW-1:0]  exp_w_dat   [$];
    logic           exp_w_last  [$];

    always #5 clk = ~clk;

    axi_aw_w_mux_ctrl #(
        .NUM_IN     (N),
        .AW_WIDTH   (AWW),
        .W_WIDTH    (WW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .test_en_i         (test_en),
        .slave_aw_valid_i  (aw_valid),
        .slave_aw_data_i   (aw_data),
        .slave_aw_ready_o  (aw_ready),
        .slave_w_valid_i   (w_valid),
        .slave_w_data_i    (w_data),
        .slave_w_last_i    (w_last),
        .slave_w_ready_o   (w_ready),
        .master_aw_valid_o (m_aw_valid),
        .master_aw_data_o  (m_aw_data),
        .master_aw_idx_o   (m_aw_idx),
        .master_aw_ready_i (m_aw_ready),
        .master_w_valid_o  (m_w_valid),
        .master_w_data_o   (m_w_data),
        .master_w_last_o   (m_w_last),
        .master_w_ready_i  (m_w_ready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_all();
        aw_valid   = '0;
        w_valid    = '0;
        w_last     = '0;
        aw_hs_seen = '0;
        w_hs_seen  = '0;
        for (int i = 0; i < N; i++) begin
            wl_head[i] = 0;
            wl_cnt[i]  = 0;
            wbeat[i]   = 0;
        end
        m_fifo.delete();
        m_ptr = 0;
        m_cur = -1;
        exp_aw_idx.delete();
        exp_aw_dat.delete();
        exp_w_dat.delete();
        exp_w_last.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_aw_valid"}, 128'(m_aw_valid), 128'(0));
        check({tag, "_aw_ready"}, 128'(aw_ready), 128'(0));
        check({tag, "_w_valid"},  128'(m_w_valid), 128'(0));
        check({tag, "_w_ready"},  128'(w_ready), 128'(0));
    endtask

    // Drive one cycle of upstream traffic; creation stops when create=0.
    task automatic drive(input bit create, input int p_aw, input int p_w);
        int len;
        for (int i = 0; i < N; i++) begin
            if (aw_hs_seen[i]) aw_valid[i] = 1'b0;
            if (!aw_valid[i] && create && wl_cnt[i] < RING && $urandom_range(0, 99) < 30) begin
                aw_valid[i] = 1'b1;
                aw_data[i*AWW +: AWW] = {$urandom(), $urandom()};
                len = int'($urandom_range(1, 4));
                wlen_buf[i][(wl_head[i] + wl_cnt[i]) % RING] = len;
                wl_cnt[i]++;
            end
            if (w_hs_seen[i]) begin
                if (w_last[i]) begin
                    wl_head[i] = (wl_head[i] + 1) % RING;
                    wl_cnt[i]--;
                    wbeat[i] = 0;
                end else begin
                    wbeat[i]++;
                end
                w_valid[i] = 1'b0;
            end
            if (!w_valid[i] && wl_cnt[i] > 0 && $urandom_range(0, 99) < 60) begin
                w_valid[i] = 1'b1;
                w_data[i*WW +: WW] = WW'({$urandom(), $urandom(), $urandom()});
                w_last[i] = (wbeat[i] == wlen_buf[i][wl_head[i]] - 1);
            end
        end
        m_aw_ready = ($urandom_range(0, 99) < p_aw);
        m_w_ready  = ($urandom_range(0, 99) < p_w);
    endtask

    // Cycle-level expectation from the arbitration and ordering rules.
    task automatic model_cycle();
        logic         e_aw_v;
        logic         e_w_v;
        logic [N-1:0] e_aw_r;
        logic [N-1:0] e_w_r;
        bit           do_push;
        bit           do_pop;
        int           h;
        e_aw_v = 1'b0; e_w_v = 1'b0; e_aw_r = '0; e_w_r = '0;
        do_push = 0; do_pop = 0; h = 0;
        if (m_cur < 0 && aw_valid != '0 && m_fifo.size() < DEPTH) m_cur = pick(aw_valid, m_ptr);
        if (m_cur >= 0) e_aw_v = aw_valid[m_cur];
        check("aw_valid", 128'(m_aw_valid), 128'(e_aw_v));
        if (e_aw_v) check("aw_idx", 128'(m_aw_idx), 128'(m_cur));
        if (e_aw_v && m_aw_ready) begin
            e_aw_r[m_cur] = 1'b1;
            do_push = 1;
        end
        check("aw_ready_vec", 128'(aw_ready), 128'(e_aw_r));
        if (m_fifo.size() > 0) begin
            h = m_fifo[0];
            e_w_v = w_valid[h];
            if (m_w_ready) e_w_r[h] = 1'b1;
        end
        check("w_valid", 128'(m_w_valid), 128'(e_w_v));
        check("w_ready_vec", 128'(w_ready), 128'(e_w_r));
        if (e_w_v && m_w_ready) begin
            exp_w_dat.push_back(w_data[h*WW +: WW]);
            exp_w_last.push_back(w_last[h]);
            do_pop = w_last[h];
        end
        if (do_push) begin
            exp_aw_idx.push_back(m_cur);
            exp_aw_dat.push_back(aw_data[m_cur*AWW +: AWW]);
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (do_push) begin
            m_fifo.push_back(m_cur);
            m_ptr = (m_cur + 1) % N;
            m_cur = -1;
        end
        aw_hs_seen = aw_valid & aw_ready;
        w_hs_seen  = w_valid & w_ready;
    endtask

    // Monitor: pops the scoreboard whenever the master port handshakes.
    initial begin
        int             ei;
        logic [AWW-1:0] ed;
        logic [WW-1:0]  wd;
        logic           wl;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && m_aw_valid && m_aw_ready) begin
                if (exp_aw_idx.size() == 0) begin
                    check("sb_aw_unexpected", 128'(1), 128'(0));
                end else begin
                    ei = exp_aw_idx.pop_front();
                    ed = exp_aw_dat.pop_front();
                    check("sb_aw_idx", 128'(m_aw_idx), 128'(ei));
                    check("sb_aw_data", 128'(m_aw_data), 128'(ed));
                end
            end
            if (rst_n && m_w_valid && m_w_ready) begin
                if (exp_w_dat.size() == 0) begin
                    check("sb_w_unexpected", 128'(1), 128'(0));
                end else begin
                    wd = exp_w_dat.pop_front();
                    wl = exp_w_last.pop_front();
                    check("sb_w_data", 128'(m_w_data), 128'(wd));
                    check("sb_w_last", 128'(m_w_last), 128'(wl));
                end
            end
        end
    end

    initial begin
        int p_aw;
        int p_w;
        clear_all();
        aw_data = {N{$urandom(), $urandom()}};
        aw_valid = 4'b0101;
        w_data[0 +: WW] = WW'({$urandom(), $urandom(), $urandom()});
        #2;
        check_quiet("reset");
        check("reset_aw_idx", 128'(m_aw_idx), 128'(0));
        check("reset_aw_data", 128'(m_aw_data), 128'(aw_data[0 +: AWW]));
        check("reset_w_data", 128'(m_w_data), 128'(w_data[0 +: WW]));
        aw_valid = '0;
        #11;
        rst_n = 1'b1;

        for (int c = 0; c < 3400; c++) begin
            if (c < 1000)      begin p_aw = 85;  p_w = 90;  end
            else if (c < 2000) begin p_aw = 40;  p_w = 15;  end
            else if (c < 3000) begin p_aw = 60;  p_w = 50;  end
            else               begin p_aw = 100; p_w = 100; end
            @(posedge clk);
            #1;
            drive(c < 3000, p_aw, p_w);
            @(negedge clk);
            model_cycle();
            if (c == 1700) begin
                #3;
                rst_n = 1'b0;
                #1;
                check_quiet("midrst");
                clear_all();
                repeat (2) @(negedge clk);
                check_quiet("inrst");
                #3;
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #3;
        check("drain_aw_sb", 128'(exp_aw_idx.size()), 128'(0));
        check("drain_w_sb", 128'(exp_w_dat.size()), 128'(0));
        check("drain_aw_req", 128'(aw_valid), 128'(0));
        check("drain_model_fifo", 128'(m_fifo.size()), 128'(0));
        check("drain_w_valid", 128'(m_w_valid), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_axi_aw_w_mux_ctrl
`default_nettype wire
